fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch initiator for the single-clock pipelined CPU datapath.
- Owns the PC, drives address/enable into the combinational instruction memory `im`, and captures the returned word into the IF/ID register.
- Accepts stall and redirect (branch/jump) requests from the decode stage.
- Sits between `im` and the ID stage.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; also the byte address of im word 0.
- IM_AW, 10, word-address width of `im` (1024 words).

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID this cycle
- redirect  in  1  branch/jump taken, from ID
- redirect_pc  in  32  byte target of redirect
- im_addr  out  IM_AW  word address to `im`
- im_enable  out  1  read enable to `im`
- im_data  in  32  instruction word from `im` (combinational, same cycle)
- if_instr  out  32  IF/ID instruction
- if_pc  out  32  IF/ID PC of if_instr
- if_pc8  out  32  if_pc + 8 (link address)
- if_valid  out  1  if_instr is a real instruction
- fetch_err  out  1  sticky bad-target error

Behaviour:
- Reset values (reset high at posedge):
  - pc = RESET_PC
  - if_instr = 0, if_pc = RESET_PC, if_pc8 = RESET_PC + 8
  - if_valid = 0, fetch_err = 0
  - state = RUN, pending redirect cleared
- Reset mid-operation discards any pending redirect and clears HALT.
- Address generation (combinational):
  - im_addr = (pc − RESET_PC)[IM_AW+1:2]; out-of-range upper bits are dropped.
  - im_enable = (state != HALT) && !stall && !reset.
- Latency: one cycle. The word for pc appears on if_instr at the next posedge.
- States:
  - RUN: normal fetch.
    - No stall, no redirect: pc += 4; IF/ID loads {im_data, pc}; if_valid = 1.
    - stall && !redirect: pc and IF/ID hold.
    - stall && redirect: record pending = redirect_pc; go to HOLD.
    - redirect && !stall: pc = redirect_pc; IF/ID flush or delay-slot load per the optional feature.
  - HOLD: stall with a redirect already recorded.
    - PC and IF/ID hold.
    - A further redirect overwrites pending (last wins).
    - When stall drops: pc = pending, apply flush/delay-slot rule, go to RUN.
  - HALT: bad redirect target.
    - Entered when an accepted target has bits[1:0] != 0, or lies outside [RESET_PC, RESET_PC + 4·2^IM_AW).
    - fetch_err = 1, if_valid = 0, im_enable = 0, pc frozen.
    - Exit only via reset.
- Target validity is checked at application time, not capture time.
- Sequential fall-through past the last im word wraps im_addr to 0. No error is raised; this is software's responsibility.
- Arithmetic: 32-bit modulo adds throughout.

Optional Feature:
- Macro: FETCH_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot): on an applied redirect, IF/ID loads the instruction at the current pc with if_valid = 1; pc = target.
- Undefined: on an applied redirect, IF/ID loads if_instr = 0 (nop) with if_valid = 0 for one cycle; pc = target.

Decomposition:
- Shared package/header `fetch.h` holds:
  - state encodings FETCH_RUN = 2'd0, FETCH_HOLD = 2'd1, FETCH_HALT = 2'd2
  - default RESET_PC
  - NOP = 32'h0
- Natural sub-module: `if_id_reg`, the IF/ID pipeline register with load, flush and hold controls.
- PC, state machine and address generation stay in fetch_unit.

Test Plan:
- Reset, then 3 free-running cycles with im word0..2 = 32'h1111_1111/2222_2222/3333_3333 → im_addr 0,1,2. if_instr follows one cycle later with if_pc 0x3000/0x3004/0x3008, if_pc8 0x3008/0x300C/0x3010, if_valid = 1.
- Assert stall for 2 cycles at pc 0x3008 → im_enable = 0, if_* unchanged, pc stays 0x3008. Fetch resumes from 0x3008.
- redirect to 0x3040 at pc 0x3004:
  - delay slot undefined: next if_valid = 0, then if_pc = 0x3040.
  - delay slot defined: next if_pc = 0x3004 with if_valid = 1, then 0x3040.
- redirect 0x3100 while stall high for 3 cycles, second redirect 0x3200 in cycle 2 → after stall drops, pc = 0x3200 (last wins).
- redirect to 0x3002 → fetch_err = 1, if_valid = 0, im_enable = 0 until reset; reset then restores pc = 0x3000 and fetch_err = 0.
- Reset asserted while in HOLD with pending 0x3100 → pending discarded, fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: state encodings, default reset PC, nop word.
package fetch_pkg;

   localparam logic [1:0]  FETCH_RUN  = 2'd0;
   localparam logic [1:0]  FETCH_HOLD = 2'd1;
   localparam logic [1:0]  FETCH_HALT = 2'd2;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP          = 32'h0;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: reset, flush (nop, invalid), load, else hold.
import fetch_pkg::*;

module if_id_reg #(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] ld_instr,
   input  logic [31:0] ld_pc,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc8,
   output logic        valid
);

   // Flush wins over load; pc/pc8 are kept on flush since valid=0 marks the slot empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr <= NOP;
         pc    <= RESET_PC;
         pc8   <= RESET_PC + 32'd8;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= NOP;
         valid <= 1'b0;
      end else if (load) begin
         instr <= ld_instr;
         pc    <= ld_pc;
         pc8   <= ld_pc + 32'd8;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, RUN/HOLD/HALT control, im addressing, IF/ID capture.
// Optional macro FETCH_DELAY_SLOT_EN: applied redirects keep the delay-slot
// instruction instead of flushing it.
import fetch_pkg::*;

module fetch_unit #(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          IM_AW    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect,
   input  logic [31:0]      redirect_pc,
   output logic [IM_AW-1:0] im_addr,
   output logic             im_enable,
   input  logic [31:0]      im_data,
   output logic [31:0]      if_instr,
   output logic [31:0]      if_pc,
   output logic [31:0]      if_pc8,
   output logic             if_valid,
   output logic             fetch_err
);

   logic [1:0]  state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] pending, pending_nxt;
   logic        err_nxt;
   logic        ld, fl;
   logic        apply;
   logic [31:0] tgt, tgt_off, pc_off;
   logic        tgt_ok;

   assign pc_off    = pc - RESET_PC;
   assign im_addr   = pc_off[IM_AW+1:2];
   assign im_enable = (state != FETCH_HALT) && !stall && !reset;

   // Target must be word aligned and inside the im window (modulo offset catches below-base too).
   assign tgt_off = tgt - RESET_PC;
   assign tgt_ok  = (tgt_off[1:0] == 2'b00) && ((tgt_off >> (IM_AW + 2)) == 32'd0);

   // Next-state: sequential fetch, redirect capture/apply, bad-target halt.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      pending_nxt = pending;
      err_nxt     = fetch_err;
      ld          = 1'b0;
      fl          = 1'b0;
      apply       = 1'b0;
      tgt         = 32'h0;
      case (state)
         FETCH_RUN: begin
            if (!stall) begin
               if (redirect) begin
                  apply = 1'b1;
                  tgt   = redirect_pc;
               end else begin
                  ld     = 1'b1;
                  pc_nxt = pc + 32'd4;
               end
            end else if (redirect) begin
               pending_nxt = redirect_pc;
               state_nxt   = FETCH_HOLD;
            end
         end
         FETCH_HOLD: begin
            if (redirect) pending_nxt = redirect_pc;
            if (!stall) begin
               apply     = 1'b1;
               tgt       = redirect ? redirect_pc : pending;
               state_nxt = FETCH_RUN;
            end
         end
         default: ;
      endcase
      if (apply) begin
         if (tgt_ok) begin
            pc_nxt = tgt;
`ifdef FETCH_DELAY_SLOT_EN
            ld = 1'b1;
`else
            fl = 1'b1;
`endif
         end else begin
            state_nxt = FETCH_HALT;
            err_nxt   = 1'b1;
            fl        = 1'b1;
         end
      end
   end

   // Control state; reset drops any pending redirect and leaves HALT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FETCH_RUN;
         pc        <= RESET_PC;
         pending   <= RESET_PC;
         fetch_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         pending   <= pending_nxt;
         fetch_err <= err_nxt;
      end
   end

   if_id_reg #(.RESET_PC(RESET_PC)) u_if_id (
      .clk      (clk),
      .reset    (reset),
      .load     (ld),
      .flush    (fl),
      .ld_instr (im_data),
      .ld_pc    (pc),
      .instr    (if_instr),
      .pc       (if_pc),
      .pc8      (if_pc8),
      .valid    (if_valid)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural combinational im.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, stall, redirect;
   logic [31:0] redirect_pc;
   logic [9:0]  im_addr;
   logic        im_enable;
   logic [31:0] im_data;
   logic [31:0] if_instr, if_pc, if_pc8;
   logic        if_valid, fetch_err;

   logic [31:0] mem [0:1023];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign im_data = mem[im_addr];

   fetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .im_addr(im_addr), .im_enable(im_enable),
      .im_data(im_data), .if_instr(if_instr), .if_pc(if_pc), .if_pc8(if_pc8),
      .if_valid(if_valid), .fetch_err(fetch_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
      mem[0] = 32'h1111_1111;
      mem[1] = 32'h2222_2222;
      mem[2] = 32'h3333_3333;

      // Reset state
      do_reset();
      chk("rst_instr", if_instr, 32'h0);
      chk("rst_pc",    if_pc,    32'h3000);
      chk("rst_pc8",   if_pc8,   32'h3008);
      chk("rst_valid", {31'b0, if_valid},  32'd0);
      chk("rst_err",   {31'b0, fetch_err}, 32'd0);
      chk("rst_addr",  {22'b0, im_addr},   32'd0);
      chk("rst_en",    {31'b0, im_enable}, 32'd1);

      // Free-running fetch, one-cycle latency
      tick();
      chk("f0_instr", if_instr, 32'h1111_1111);
      chk("f0_pc",    if_pc,    32'h3000);
      chk("f0_pc8",   if_pc8,   32'h3008);
      chk("f0_valid", {31'b0, if_valid}, 32'd1);
      chk("f0_addr",  {22'b0, im_addr},  32'd1);
      tick();
      chk("f1_instr", if_instr, 32'h2222_2222);
      chk("f1_pc",    if_pc,    32'h3004);
      chk("f1_pc8",   if_pc8,   32'h300C);
      chk("f1_addr",  {22'b0, im_addr},  32'd2);

      // Stall two cycles at pc 0x3008
      stall = 1'b1; #1;
      chk("st_en", {31'b0, im_enable}, 32'd0);
      tick();
      tick();
      chk("st_instr", if_instr, 32'h2222_2222);
      chk("st_pc",    if_pc,    32'h3004);
      chk("st_addr",  {22'b0, im_addr}, 32'd2);
      stall = 1'b0; #1;
      chk("st_en_back", {31'b0, im_enable}, 32'd1);
      tick();
      chk("f2_instr", if_instr, 32'h3333_3333);
      chk("f2_pc",    if_pc,    32'h3008);
      chk("f2_pc8",   if_pc8,   32'h3010);
      chk("f2_valid", {31'b0, if_valid}, 32'd1);

      // Redirect to 0x3040 issued while pc = 0x3004
      do_reset();
      tick();
      redirect = 1'b1; redirect_pc = 32'h3040;
      tick();
      redirect = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
      chk("rd_slot_pc",    if_pc,    32'h3004);
      chk("rd_slot_instr", if_instr, 32'h2222_2222);
      chk("rd_slot_valid", {31'b0, if_valid}, 32'd1);
`else
      chk("rd_flush_instr", if_instr, 32'h0);
      chk("rd_flush_valid", {31'b0, if_valid}, 32'd0);
`endif
      chk("rd_addr", {22'b0, im_addr}, 32'h10);
      tick();
      chk("rd_tgt_pc",    if_pc,    32'h3040);
      chk("rd_tgt_instr", if_instr, 32'hC0DE_0010);
      chk("rd_tgt_valid", {31'b0, if_valid}, 32'd1);

      // Redirect during 3-cycle stall, second redirect wins
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3100;
      tick();
      redirect_pc = 32'h3200;
      tick();
      redirect = 1'b0; redirect_pc = 32'h0;
      tick();
      chk("hold_en",   {31'b0, im_enable}, 32'd0);
      chk("hold_addr", {22'b0, im_addr},  32'h11);
      stall = 1'b0;
      tick();
      chk("lw_addr", {22'b0, im_addr}, 32'h80);
      tick();
      chk("lw_pc",    if_pc,    32'h3200);
      chk("lw_instr", if_instr, 32'hC0DE_0080);

      // Last im word falls through to word 0
      redirect = 1'b1; redirect_pc = 32'h3FFC;
      tick();
      redirect = 1'b0;
      chk("wrap_last", {22'b0, im_addr}, 32'h3FF);
      tick();
      chk("wrap_zero", {22'b0, im_addr}, 32'd0);
      chk("wrap_err",  {31'b0, fetch_err}, 32'd0);

      // Misaligned target halts until reset
      redirect = 1'b1; redirect_pc = 32'h3002;
      tick();
      redirect = 1'b0;
      tick();
      tick();
      chk("halt_err",   {31'b0, fetch_err}, 32'd1);
      chk("halt_valid", {31'b0, if_valid},  32'd0);
      chk("halt_en",    {31'b0, im_enable}, 32'd0);
      do_reset();
      chk("halt_rst_err",  {31'b0, fetch_err}, 32'd0);
      chk("halt_rst_addr", {22'b0, im_addr},  32'd0);
      chk("halt_rst_en",   {31'b0, im_enable}, 32'd1);

      // Below-window target also halts
      redirect = 1'b1; redirect_pc = 32'h2FFC;
      tick();
      redirect = 1'b0;
      chk("low_err", {31'b0, fetch_err}, 32'd1);
      // Just-past-window target halts
      do_reset();
      redirect = 1'b1; redirect_pc = 32'h4000;
      tick();
      redirect = 1'b0;
      chk("high_err", {31'b0, fetch_err}, 32'd1);

      // Reset during HOLD drops the pending redirect
      do_reset();
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3100;
      tick();
      redirect = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0; stall = 1'b0;
      #1;
      chk("hr_addr", {22'b0, im_addr}, 32'd0);
      tick();
      chk("hr_pc",    if_pc,    32'h3000);
      chk("hr_instr", if_instr, 32'h1111_1111);
      chk("hr_addr2", {22'b0, im_addr}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
